// File: rtl/kc_ls1u_pkg.sv
// Shared encodings for the KC-LS1u parametrised core: opcodes, jump selects,
// destination codes and write-back source selection.
package kc_ls1u_pkg;

    localparam logic [4:0] F5_NOP    = 5'h00;
    localparam logic [4:0] F5_JMP    = 5'h01;
    localparam logic [4:0] F5_ALU    = 5'h02;
    localparam logic [4:0] F5_LOAD   = 5'h04;
    localparam logic [4:0] F5_MOVC   = 5'h05;
    localparam logic [4:0] F5_IMM    = 5'h06;
    localparam logic [4:0] F5_MOVD   = 5'h07;
    localparam logic [4:0] F5_SHL_A  = 5'h0d;
    localparam logic [4:0] F5_SLC_AB = 5'h10;
    localparam logic [4:0] F5_SHR_A  = 5'h12;
    localparam logic [4:0] F5_ASR_A  = 5'h14;
    localparam logic [4:0] F5_SHL_B  = 5'h16;
    localparam logic [4:0] F5_SHR_B  = 5'h18;
    localparam logic [4:0] F5_ASR_B  = 5'h1a;
    localparam logic [4:0] F5_SRC_AB = 5'h1c;

    localparam logic [2:0] JS_RET  = 3'd0;
    localparam logic [2:0] JS_APOS = 3'd1;
    localparam logic [2:0] JS_BPOS = 3'd2;
    localparam logic [2:0] JS_NEQ  = 3'd3;
    localparam logic [2:0] JS_NC   = 3'd4;
    localparam logic [2:0] JS_ALW  = 3'd5;

    localparam logic [2:0] DST_C   = 3'd0;
    localparam logic [2:0] DST_A   = 3'd1;
    localparam logic [2:0] DST_B   = 3'd2;
    localparam logic [2:0] DST_A0  = 3'd3;
    localparam logic [2:0] DST_A1  = 3'd4;
    localparam logic [2:0] DST_A2  = 3'd5;
    localparam logic [2:0] DST_D   = 3'd6;
    localparam logic [2:0] DST_MDR = 3'd7;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD,
        WB_C,
        WB_IMM,
        WB_D,
        WB_SHIFT
    } wb_src_e;

    localparam int IVT_STRIDE = 4;

endpackage

// File: rtl/alu74181.sv
// 4-bit 74181-style ALU slice, active-high data and active-high carry in/out.
// aeqb is the classic A=B output: high when F is all ones.
module alu74181 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       cin_i,
    output logic [3:0] f_o,
    output logic       cout_o,
    output logic       aeqb_o
);

    logic [3:0] x, y, lf;
    logic [4:0] sum;

    // Every arithmetic function is expressed as X + Y + Cin; "minus 1" is + 4'hF.
    always_comb begin
        x = a_i;
        y = 4'h0;
        case (s_i)
            4'b0000: begin x = a_i;         y = 4'h0;         end
            4'b0001: begin x = a_i | b_i;   y = 4'h0;         end
            4'b0010: begin x = a_i | ~b_i;  y = 4'h0;         end
            4'b0011: begin x = 4'h0;        y = 4'hF;         end
            4'b0100: begin x = a_i;         y = a_i & ~b_i;   end
            4'b0101: begin x = a_i | b_i;   y = a_i & ~b_i;   end
            4'b0110: begin x = a_i;         y = ~b_i;         end
            4'b0111: begin x = a_i & ~b_i;  y = 4'hF;         end
            4'b1000: begin x = a_i;         y = a_i & b_i;    end
            4'b1001: begin x = a_i;         y = b_i;          end
            4'b1010: begin x = a_i | ~b_i;  y = a_i & b_i;    end
            4'b1011: begin x = a_i & b_i;   y = 4'hF;         end
            4'b1100: begin x = a_i;         y = a_i;          end
            4'b1101: begin x = a_i | b_i;   y = a_i;          end
            4'b1110: begin x = a_i | ~b_i;  y = a_i;          end
            default: begin x = a_i;         y = 4'hF;         end
        endcase
    end

    always_comb begin
        lf = ~a_i;
        case (s_i)
            4'b0000: lf = ~a_i;
            4'b0001: lf = ~(a_i | b_i);
            4'b0010: lf = ~a_i & b_i;
            4'b0011: lf = 4'h0;
            4'b0100: lf = ~(a_i & b_i);
            4'b0101: lf = ~b_i;
            4'b0110: lf = a_i ^ b_i;
            4'b0111: lf = a_i & ~b_i;
            4'b1000: lf = ~a_i | b_i;
            4'b1001: lf = ~(a_i ^ b_i);
            4'b1010: lf = b_i;
            4'b1011: lf = a_i & b_i;
            4'b1100: lf = 4'hF;
            4'b1101: lf = a_i | ~b_i;
            4'b1110: lf = a_i | b_i;
            default: lf = a_i;
        endcase
    end

    assign sum    = 5'(x) + 5'(y) + 5'(cin_i);
    assign f_o    = m_i ? lf : sum[3:0];
    assign cout_o = m_i ? 1'b0 : sum[4];
    assign aeqb_o = (f_o == 4'hF);

endmodule

// File: rtl/kc_ls1u_retstack.sv
// Return-address LIFO. Push when full and pop when empty are ignored;
// the top reads as zero while the stack is empty.
module kc_ls1u_retstack #(
    parameter int  RSD = 4,
    parameter int  W   = 24,
    localparam int DPW = $clog2(RSD + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   data_i,
    output logic [W-1:0]   top_o,
    output logic [DPW-1:0] depth_o,
    output logic           full_o,
    output logic           empty_o
);

    logic [W-1:0]   mem_q [RSD];
    logic [DPW-1:0] depth_q;

    assign full_o  = (depth_q == DPW'(RSD));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            for (int i = 0; i < RSD; i++) mem_q[i] <= '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < RSD; i++) begin
                if (i == int'(depth_q)) mem_q[i] <= data_i;
            end
            depth_q <= depth_q + DPW'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - DPW'(1);
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < RSD; i++) begin
            if (int'(depth_q) == i + 1) top_o = mem_q[i];
        end
    end

endmodule

// File: rtl/kc_ls1u_core_p.sv
// KC-LS1u parametrised accumulator core with handshaked data bus and stacked
// interrupts. Define KC_LS1U_NESTED_INT_EN to allow interrupts inside an ISR.
module kc_ls1u_core_p
    import kc_ls1u_pkg::*;
#(
    parameter int  DW  = 8,
    parameter int  NAR = 3,
    parameter int  RSD = 4,
    localparam int AW  = NAR * DW,
    localparam int DPW = $clog2(RSD + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           irq,
    input  logic [5:0]     irq_code,
    input  logic [AW-1:0]  ivt_base,
    input  logic           stall,
    output logic [AW-1:0]  iaddr,
    input  logic [15:0]    instr,
    output logic [AW-1:0]  daddr,
    output logic           dread,
    output logic           dwrite,
    input  logic           dready,
    input  logic [DW-1:0]  ddata_i,
    output logic [DW-1:0]  ddata_o,
    output logic           int_ack,
    output logic [DPW-1:0] rs_depth
);

    localparam int NSL = DW / 4;

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] c_q, c_d, a_q, a_d, b_q, b_d, d_q, d_d, mdr_q, mdr_d;
    logic [DW-1:0] ar_q [NAR];
    logic [DW-1:0] ar_d [NAR];
    logic          dwrite_q, dwrite_d, int_ack_q, int_ack_d;

    logic [4:0]    f5;
    logic [2:0]    dst;
    logic [DW-1:0] imm, shf, wdata;
    wb_src_e       wb_src;
    logic          wen;

    logic [DW-1:0]  alu_f;
    logic [NSL-1:0] sl_cout, sl_eqv;
    logic           alu_carry, alu_eq;

    logic [AW-1:0]  addr_cat, pc_inc, vec;
    logic           jmp_taken, mask, irq_accept;
    logic           stk_push, stk_pop, stk_full, stk_empty;
    logic [AW-1:0]  stk_top;
    logic [DPW-1:0] stk_depth;

    assign f5  = stall ? F5_NOP : instr[15:11];
    assign dst = instr[10:8];
    assign imm = DW'(instr[7:0]);

    for (genvar g = 0; g < NSL; g++) begin : g_alu
        alu74181 u_alu (
            .a_i    (a_q[4*g +: 4]),
            .b_i    (b_q[4*g +: 4]),
            .s_i    (instr[7:4]),
            .m_i    (instr[3]),
            .cin_i  (instr[2]),
            .f_o    (alu_f[4*g +: 4]),
            .cout_o (sl_cout[g]),
            .aeqb_o (sl_eqv[g])
        );
    end

    assign alu_carry = sl_cout[NSL-1];
    assign alu_eq    = &sl_eqv;

    kc_ls1u_retstack #(.RSD(RSD), .W(AW)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_q),
        .top_o   (stk_top),
        .depth_o (stk_depth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

`ifdef KC_LS1U_NESTED_INT_EN
    assign mask = stk_full;
`else
    assign mask = !stk_empty || stk_full;
`endif

    always_comb begin
        addr_cat = '0;
        for (int i = 0; i < NAR; i++) addr_cat[i*DW +: DW] = ar_q[i];
    end

    assign pc_inc     = pc_q + AW'(1);
    assign vec        = ivt_base + (AW'(irq_code) * AW'(IVT_STRIDE));
    assign dread      = (f5 == F5_LOAD) && !dwrite_q;
    assign irq_accept = irq && !stall && !dwrite_q && !dread && !mask;

    always_comb begin
        wb_src = WB_NONE;
        shf    = a_q;
        case (f5)
            F5_ALU:    wb_src = WB_ALU;
            F5_LOAD:   wb_src = WB_LOAD;
            F5_MOVC:   wb_src = WB_C;
            F5_IMM:    wb_src = WB_IMM;
            F5_MOVD:   wb_src = WB_D;
            F5_SHL_A:  begin wb_src = WB_SHIFT; shf = {a_q[DW-2:0], 1'b0};      end
            F5_SLC_AB: begin wb_src = WB_SHIFT; shf = {a_q[DW-2:0], b_q[DW-1]}; end
            F5_SHR_A:  begin wb_src = WB_SHIFT; shf = {1'b0, a_q[DW-1:1]};      end
            F5_ASR_A:  begin wb_src = WB_SHIFT; shf = {a_q[DW-1], a_q[DW-1:1]}; end
            F5_SHL_B:  begin wb_src = WB_SHIFT; shf = {b_q[DW-2:0], 1'b0};      end
            F5_SHR_B:  begin wb_src = WB_SHIFT; shf = {1'b0, b_q[DW-1:1]};      end
            F5_ASR_B:  begin wb_src = WB_SHIFT; shf = {b_q[DW-1], b_q[DW-1:1]}; end
            F5_SRC_AB: begin wb_src = WB_SHIFT; shf = {a_q[0], b_q[DW-1:1]};    end
            default:   wb_src = WB_NONE;
        endcase
    end

    always_comb begin
        case (wb_src)
            WB_ALU:   wdata = alu_f;
            WB_LOAD:  wdata = ddata_i;
            WB_C:     wdata = c_q;
            WB_IMM:   wdata = imm;
            WB_D:     wdata = d_q;
            WB_SHIFT: wdata = shf;
            default:  wdata = '0;
        endcase
    end

    always_comb begin
        case (instr[10:8])
            JS_APOS: jmp_taken = !a_q[DW-1];
            JS_BPOS: jmp_taken = !b_q[DW-1];
            JS_NEQ:  jmp_taken = !alu_eq;
            JS_NC:   jmp_taken = !alu_carry;
            JS_ALW:  jmp_taken = 1'b1;
            default: jmp_taken = 1'b0;
        endcase
    end

    // Sequencing priority: stall, pending store, pending load, interrupt, execute.
    always_comb begin
        pc_d      = pc_q;
        wen       = 1'b0;
        dwrite_d  = dwrite_q;
        int_ack_d = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (dwrite_q) begin
            if (dready) dwrite_d = 1'b0;
        end else if (dread) begin
            if (dready) begin
                wen  = 1'b1;
                pc_d = pc_inc;
            end
        end else if (irq_accept) begin
            stk_push  = 1'b1;
            pc_d      = vec;
            int_ack_d = 1'b1;
        end else begin
            wen  = (wb_src != WB_NONE);
            pc_d = pc_inc;
            if (f5 == F5_JMP) begin
                if (instr[10:8] == JS_RET) begin
                    if (!stk_empty) begin
                        pc_d    = stk_top;
                        stk_pop = 1'b1;
                    end
                end else if (jmp_taken) begin
                    pc_d = addr_cat;
                end
            end
        end
        if (wen && dst == DST_MDR) dwrite_d = 1'b1;
    end

    always_comb begin
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        d_d   = d_q;
        mdr_d = mdr_q;
        ar_d  = ar_q;
        if (wen) begin
            case (dst)
                DST_C:   c_d   = wdata;
                DST_A:   a_d   = wdata;
                DST_B:   b_d   = wdata;
                DST_D:   d_d   = wdata;
                DST_MDR: mdr_d = wdata;
                default: begin
                    for (int i = 0; i < NAR; i++) begin
                        if (i < 3 && int'(dst) == int'(DST_A0) + i) ar_d[i] = wdata;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            c_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            mdr_q     <= '0;
            dwrite_q  <= 1'b0;
            int_ack_q <= 1'b0;
            for (int i = 0; i < NAR; i++) ar_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            c_q       <= c_d;
            a_q       <= a_d;
            b_q       <= b_d;
            d_q       <= d_d;
            mdr_q     <= mdr_d;
            dwrite_q  <= dwrite_d;
            int_ack_q <= int_ack_d;
            ar_q      <= ar_d;
        end
    end

    assign iaddr    = pc_q;
    assign daddr    = addr_cat;
    assign dwrite   = dwrite_q;
    assign ddata_o  = mdr_q;
    assign int_ack  = int_ack_q;
    assign rs_depth = stk_depth;

endmodule

// File: tb/tb_kc_ls1u_core_p.sv
// Directed bench for kc_ls1u_core_p: stimulus queues expected port values per
// cycle, a negedge monitor pops and compares them.
module tb_kc_ls1u_core_p;

    localparam int DW  = 8;
    localparam int NAR = 3;
    localparam int RSD = 2;
    localparam int AW  = NAR * DW;
    localparam int DPW = $clog2(RSD + 1);

    localparam int S_IADDR = 0, S_DADDR = 1, S_DREAD = 2, S_DWRITE = 3,
                   S_DDATA = 4, S_ACK = 5, S_DEPTH = 6;

    logic           clk;
    logic           rst;
    logic           irq;
    logic [5:0]     irq_code;
    logic [AW-1:0]  ivt_base;
    logic           stall;
    logic [AW-1:0]  iaddr;
    logic [15:0]    instr;
    logic [AW-1:0]  daddr;
    logic           dread;
    logic           dwrite;
    logic           dready;
    logic [DW-1:0]  ddata_i;
    logic [DW-1:0]  ddata_o;
    logic           int_ack;
    logic [DPW-1:0] rs_depth;

    kc_ls1u_core_p #(.DW(DW), .NAR(NAR), .RSD(RSD)) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .irq_code (irq_code),
        .ivt_base (ivt_base),
        .stall    (stall),
        .iaddr    (iaddr),
        .instr    (instr),
        .daddr    (daddr),
        .dread    (dread),
        .dwrite   (dwrite),
        .dready   (dready),
        .ddata_i  (ddata_i),
        .ddata_o  (ddata_o),
        .int_ack  (int_ack),
        .rs_depth (rs_depth)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_IADDR:  return 32'(iaddr);
            S_DADDR:  return 32'(daddr);
            S_DREAD:  return 32'(dread);
            S_DWRITE: return 32'(dwrite);
            S_DDATA:  return 32'(ddata_o);
            S_ACK:    return 32'(int_ack);
            default:  return 32'(rs_depth);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            logic [31:0] act;
            e   = sb.pop_front();
            act = sample(e.sig);
            n_checks++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", e.nm, e.cyc, act, e.val);
            end
        end
    end

    task automatic chk(input int s, input logic [31:0] v, input string nm);
        sb.push_back('{cyc, s, v, nm});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Hand-assembled words: {f5, dst/jsel, imm}
    localparam logic [15:0] I_NOP = 16'h0000;
    localparam logic [15:0] I_RET = 16'h0800;

    initial begin
        rst = 1'b1; irq = 1'b0; irq_code = 6'd0; ivt_base = '0; stall = 1'b0;
        instr = I_NOP; dready = 1'b0; ddata_i = '0;
        nxt();
        chk(S_IADDR, 0, "rst_pc");    chk(S_DWRITE, 0, "rst_dwrite");
        chk(S_DREAD, 0, "rst_dread"); chk(S_ACK, 0, "rst_ack");
        chk(S_DEPTH, 0, "rst_depth"); chk(S_DDATA, 0, "rst_mdr");
        chk(S_DADDR, 0, "rst_daddr");
        nxt(); rst = 1'b0;

        // IMM C=0x12; MOV A<=C; A0<=ALU(F=A); A1<=C
        instr = 16'h3012; chk(S_IADDR, 0, "pc0"); nxt();
        instr = 16'h2900; chk(S_IADDR, 1, "pc1"); nxt();
        instr = 16'h13F8; chk(S_IADDR, 2, "pc2"); nxt();
        instr = 16'h2C00; chk(S_IADDR, 3, "pc3"); chk(S_DADDR, 24'h000012, "mov_a"); nxt();
        instr = 16'h3400; chk(S_DADDR, 24'h001212, "c_kept"); nxt();
        instr = 16'h3340; nxt();
        instr = 16'h375A; chk(S_DADDR, 24'h000040, "daddr_set"); chk(S_DWRITE, 0, "dwrite_pre"); nxt();

        // Store with dready low for three cycles
        instr = 16'h33AA; dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(S_DWRITE, 1, "st_dwrite"); chk(S_IADDR, 7, "st_pc_hold");
            chk(S_DDATA, 8'h5A, "st_mdr"); chk(S_DADDR, 24'h000040, "st_daddr");
            nxt();
        end
        dready = 1'b1; chk(S_DWRITE, 1, "st_dwrite_last"); chk(S_IADDR, 7, "st_pc_last"); nxt();

        // Load into A0 with one wait cycle
        instr = 16'h2300; dready = 1'b0; ddata_i = 8'h77;
        chk(S_DWRITE, 0, "st_done"); chk(S_DADDR, 24'h000040, "st_no_exec");
        chk(S_DREAD, 1, "ld_dread"); chk(S_IADDR, 7, "ld_pc"); nxt();
        dready = 1'b1; chk(S_DREAD, 1, "ld_dread2"); chk(S_IADDR, 7, "ld_pc2"); nxt();
        dready = 1'b0; instr = 16'h31FF;
        chk(S_IADDR, 8, "ld_adv"); chk(S_DADDR, 24'h000077, "ld_data"); chk(S_DREAD, 0, "ld_end"); nxt();

        // Jumps: A=FF, B=01, ADD with Cin -> carry set
        instr = 16'h3201; nxt();
        instr = 16'h0C94; chk(S_IADDR, 24'h00000A, "pc_jnc"); nxt();
        instr = 16'h0994; chk(S_IADDR, 24'h00000B, "jnc_not_taken"); nxt();
        instr = 16'h0D94; chk(S_IADDR, 24'h00000C, "japos_not_taken"); nxt();
        instr = 16'h3320; chk(S_IADDR, 24'h000077, "jalw_taken"); nxt();
        instr = 16'h0D00; chk(S_IADDR, 24'h000078, "pc_78"); nxt();

        // Interrupt at 0x20
        ivt_base = 24'h001000; irq = 1'b1; irq_code = 6'd5; instr = 16'h33EE;
        chk(S_IADDR, 24'h000020, "at_20"); chk(S_DEPTH, 0, "pre_irq_depth"); chk(S_ACK, 0, "pre_ack"); nxt();
        irq_code = 6'd6; instr = I_NOP;
        chk(S_IADDR, 24'h001014, "irq_vec"); chk(S_ACK, 1, "irq_ack");
        chk(S_DEPTH, 1, "irq_depth1"); chk(S_DADDR, 24'h000020, "irq_suppress"); nxt();
`ifdef KC_LS1U_NESTED_INT_EN
        chk(S_IADDR, 24'h001018, "nest_vec"); chk(S_ACK, 1, "nest_ack"); chk(S_DEPTH, 2, "nest_depth2"); nxt();
        irq = 1'b0; instr = I_RET;
        chk(S_IADDR, 24'h001019, "full_ignored"); chk(S_ACK, 0, "full_no_ack"); chk(S_DEPTH, 2, "full_depth"); nxt();
        chk(S_IADDR, 24'h001014, "ret_inner"); chk(S_DEPTH, 1, "ret_inner_depth"); nxt();
`else
        irq = 1'b0; instr = I_RET;
        chk(S_IADDR, 24'h001015, "single_ignored"); chk(S_ACK, 0, "single_no_ack"); chk(S_DEPTH, 1, "single_depth"); nxt();
`endif
        chk(S_IADDR, 24'h000020, "ret_outer"); chk(S_DEPTH, 0, "ret_depth0"); nxt();
        chk(S_IADDR, 24'h000021, "ret_empty_nop"); chk(S_DEPTH, 0, "ret_empty_depth");

        // Stall blocks both execution and interrupts
        stall = 1'b1; irq = 1'b1; irq_code = 6'd5; instr = 16'h33AB; nxt();
        stall = 1'b0; irq = 1'b0; instr = I_NOP;
        chk(S_IADDR, 24'h000021, "stall_hold"); chk(S_ACK, 0, "stall_no_ack");
        chk(S_DEPTH, 0, "stall_depth"); chk(S_DADDR, 24'h000020, "stall_no_exec"); nxt();

        // Reset in the middle of a store inside an ISR
        irq = 1'b1; chk(S_IADDR, 24'h000022, "pc_22"); nxt();
        irq = 1'b0; instr = 16'h3711; chk(S_IADDR, 24'h001014, "isr2"); chk(S_DEPTH, 1, "isr2_depth"); nxt();
        chk(S_DWRITE, 1, "mid_store"); chk(S_DDATA, 8'h11, "mid_mdr"); chk(S_DEPTH, 1, "mid_depth"); nxt();
        rst = 1'b1;
        chk(S_DWRITE, 0, "arst_dwrite"); chk(S_IADDR, 0, "arst_pc");
        chk(S_DEPTH, 0, "arst_depth"); chk(S_DDATA, 0, "arst_mdr");
        nxt(); rst = 1'b0;
        @(negedge clk); #1;

        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
